// File: rtl/vwiden_if.sv
// Handshake and payload bundle between the vALU issue stage and the sequential widener.
interface vwiden_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SEW_WIDTH  = 2
) ();
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_vec0;
    logic [DATA_WIDTH-1:0] in_vec1;
    logic [SEW_WIDTH-1:0]  in_sew;
    logic                  in_quad;
    logic                  in_signed;
    logic [BE_WIDTH-1:0]   in_be;
    logic                  in_flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_vec0;
    logic [DATA_WIDTH-1:0] out_vec1;
    logic [BE_WIDTH-1:0]   out_be;
    logic [SEW_WIDTH-1:0]  out_sew;
    logic [1:0]            out_beat;
    logic                  out_last;
    logic                  out_illegal;

    modport master (
        output in_valid, in_vec0, in_vec1, in_sew, in_quad, in_signed, in_be, in_flush, out_ready,
        input  in_ready, out_valid, out_vec0, out_vec1, out_be, out_sew, out_beat, out_last, out_illegal
    );

    modport slave (
        input  in_valid, in_vec0, in_vec1, in_sew, in_quad, in_signed, in_be, in_flush, out_ready,
        output in_ready, out_valid, out_vec0, out_vec1, out_be, out_sew, out_beat, out_last, out_illegal
    );
endinterface

// File: rtl/vwiden_seq.sv
// Sequential double/quad widener: one source word pair in, 2 or 4 widened beats out.
module vwiden_seq #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SEW_WIDTH  = 2,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic     clk,
    input  logic     rst_n,
    vwiden_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);
    localparam int unsigned BIDX_W = $clog2(BE_WIDTH);

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] vec0;
        logic [DATA_WIDTH-1:0] vec1;
        logic [SEW_WIDTH-1:0]  sew;
        logic                  quad;
        logic                  sgn;
        logic [BE_WIDTH-1:0]   be;
    } word_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] vec0;
        logic [DATA_WIDTH-1:0] vec1;
        logic [BE_WIDTH-1:0]   be;
        logic [SEW_WIDTH-1:0]  sew;
        logic [1:0]            beat;
        logic                  last;
        logic                  illegal;
    } beat_t;

    // Build beat k of a word; all widths are powers of two so index math is shifts and masks.
    function automatic beat_t calc_beat(input word_t w, input logic [1:0] k);
        beat_t r;
        int    lf, sb, ew_sh, base, e, p, src;
        logic  ext;
        r  = '0;
        lf = w.quad ? 2 : 1;
        if (int'(w.sew) + lf > 3) begin
            r.vec0    = w.vec0;
            r.vec1    = w.vec1;
            r.be      = w.be;
            r.sew     = w.sew;
            r.last    = 1'b1;
            r.illegal = 1'b1;
        end else begin
            sb    = 3 + int'(w.sew);
            ew_sh = sb + lf;
            base  = int'(k) << (int'(IDX_W) - lf);
            for (int j = 0; j < int'(DATA_WIDTH); j++) begin
                e   = j >> ew_sh;
                p   = j & ((1 << ew_sh) - 1);
                ext = (p >= (1 << sb));
                src = base + (e << sb) + (ext ? (1 << sb) - 1 : p);
                r.vec0[j] = ext ? (w.sgn & w.vec0[IDX_W'(src)]) : w.vec0[IDX_W'(src)];
                r.vec1[j] = ext ? (w.sgn & w.vec1[IDX_W'(src)]) : w.vec1[IDX_W'(src)];
            end
            for (int b = 0; b < int'(BE_WIDTH); b++) begin
                r.be[b] = w.be[BIDX_W'((base >> 3) + (b >> lf))];
            end
            r.sew  = SEW_WIDTH'(int'(w.sew) + lf);
            r.beat = k;
            r.last = (int'(k) == (1 << lf) - 1);
        end
        return r;
    endfunction

    state_t state, state_n;
    word_t  hold_q, in_word;
    beat_t  out_q, out_n;
    logic   valid_q, valid_n;
    logic   in_ready_c, accept_c;

    // Next-state and next-beat selection; flush beats any handshake in the same cycle.
    always_comb begin
        state_n    = state;
        valid_n    = valid_q;
        out_n      = out_q;
        in_word    = '{vec0: bus.in_vec0, vec1: bus.in_vec1, sew: bus.in_sew,
                       quad: bus.in_quad, sgn: bus.in_signed, be: bus.in_be};
        in_ready_c = !bus.in_flush &&
                     ((state == IDLE) || (state == EMIT && valid_q && bus.out_ready && out_q.last));
        accept_c   = bus.in_valid && in_ready_c;

        if (bus.in_flush) begin
            state_n       = IDLE;
            valid_n       = 1'b0;
            out_n.beat    = 2'd0;
            out_n.last    = 1'b0;
            out_n.illegal = 1'b0;
        end else if (accept_c) begin
            state_n = EMIT;
            valid_n = 1'b1;
            out_n   = calc_beat(in_word, 2'd0);
        end else if (state == EMIT && bus.out_ready) begin
            if (out_q.last) begin
                state_n       = IDLE;
                valid_n       = 1'b0;
                out_n.beat    = 2'd0;
                out_n.last    = 1'b0;
                out_n.illegal = 1'b0;
            end else begin
                out_n = calc_beat(hold_q, out_q.beat + 2'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            out_q   <= '0;
            hold_q  <= '0;
        end else begin
            state   <= state_n;
            valid_q <= valid_n;
            out_q   <= out_n;
            if (accept_c) hold_q <= in_word;
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = valid_q;
    assign bus.out_vec0    = out_q.vec0;
    assign bus.out_vec1    = out_q.vec1;
    assign bus.out_be      = out_q.be;
    assign bus.out_sew     = out_q.sew;
    assign bus.out_beat    = out_q.beat;
    assign bus.out_last    = out_q.last;
    assign bus.out_illegal = out_q.illegal;
endmodule

// File: doc/vwiden_seq.md
Name: vwiden_seq

Overview:
- Sequential, handshaked widening unit in the vALU datapath.
- Accepts one packed source word pair (vs2/vs1) at SEW and emits the widened result as 2 beats (2×SEW, double) or 4 beats (4×SEW, quad) on consecutive accepted cycles.
- Each beat carries sign- or zero-extended elements, an expanded byte-enable and the destination SEW.
- Generalises the single-cycle turn-selected widener: on-chip beat sequencing, quad mode, illegal-SEW detection and flush.

Parameters:
- DATA_WIDTH, 64, datapath width in bits; power of two, ≥32.
- SEW_WIDTH, 2, SEW encoding width (0=8b, 1=16b, 2=32b, 3=64b).
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source word valid.
- in_ready  out  1  unit can accept a source word this cycle.
- in_vec0  in  DATA_WIDTH  source operand 0.
- in_vec1  in  DATA_WIDTH  source operand 1.
- in_sew  in  SEW_WIDTH  source element width.
- in_quad  in  1  0 = double widening, 1 = quad widening.
- in_signed  in  1  1 = sign-extend, 0 = zero-extend.
- in_be  in  BE_WIDTH  source byte enables.
- in_flush  in  1  synchronous abort of the current sequence.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_vec0  out  DATA_WIDTH  widened operand 0 beat.
- out_vec1  out  DATA_WIDTH  widened operand 1 beat.
- out_be  out  BE_WIDTH  widened byte enables.
- out_sew  out  SEW_WIDTH  destination SEW.
- out_beat  out  2  beat index, 0..N-1.
- out_last  out  1  final beat of the sequence.
- out_illegal  out  1  SEW/mode combination cannot widen.

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; out_valid, out_beat, out_last, out_illegal, out_vec0/1, out_be, out_sew all 0; input holding register cleared.
- Factor F = 2 (in_quad=0) or 4 (in_quad=1). Number of beats N = F.
- Illegal when in_sew + log2(F) > 3 (double with sew=3; quad with sew≥2). Illegal words produce exactly one beat:
  - data and be passed through unchanged;
  - out_sew = in_sew;
  - out_illegal = 1, out_last = 1.
- Legal sequences:
  - Beat k uses slice in_vec[k*DATA_WIDTH/N +: DATA_WIDTH/N].
  - Each SEW-bit element in the slice extends to F*SEW bits; extension bit = in_signed & element MSB.
  - out_sew = in_sew + log2(F).
  - out_be: each source byte in the slice's byte range is replicated F times, in order.
- States:
  - IDLE: in_ready = 1. On in_valid, register all inputs, go to EMIT, and drive beat 0 with out_valid = 1 on the next cycle (latency 1).
  - EMIT: output registers hold stable while out_valid & !out_ready. On out_ready, advance to beat k+1. On the last beat, go to IDLE, or reload if a new word is accepted in the same cycle.
- in_ready = IDLE | (EMIT & out_valid & out_ready & out_last). This gives back-to-back sequences with no bubble.
- in_flush, when asserted:
  - next cycle: state IDLE, out_valid = 0, out_beat = 0;
  - any in_valid in the same cycle is ignored;
  - in_ready is forced to 0 during the flush cycle.
- Word accepted while asserting in_flush: dropped (flush wins).
- Holding register is not updated except on an in_valid & in_ready handshake.
- Reset mid-sequence: immediate return to the reset values; no partial beats are emitted afterwards.

Test Plan:
- Double, signed, sew=0, in_vec0=64'h0000_0000_80FF_017F, in_be=8'h81, out_ready=1 -> beat0 vec0=64'hFF80_FFFF_0001_007F, be=8'h03, sew=1, last=0; beat1 vec0=0, be=8'hC0, last=1.
- Quad, unsigned, sew=1, in_vec0=64'hFFFF_8000_1234_ABCD, in_be=8'h04 -> beats 0..3 vec0=64'hABCD, 64'h1234, 64'h8000, 64'hFFFF; be 8'h00, 8'h0F, 8'h00, 8'h00; out_sew=3; last only on beat 3.
- Backpressure: out_ready low for 3 cycles during beat1 of a double sequence -> outputs stable, in_ready=0. Release -> beat1, then beat0 of a queued word on the next cycle (no bubble).
- Illegal: double with sew=3 and quad with sew=2 -> one beat each, data unchanged, out_illegal=1, out_last=1, out_sew=in_sew.
- in_flush during beat2 of a quad sequence -> out_valid=0 next cycle, in_ready=1 the following cycle. A new word then starts at beat 0.
- rst_n pulsed low mid-sequence (asynchronously, between clock edges) -> all outputs 0 immediately. After release, a fresh sequence behaves per the first test.
